// File: rtl/muldiv_unit_if.sv
// Sequencer-to-mul/div handshake bundle: request/opcode/operands in, busy/done/result back.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] zlo;
    logic [WIDTH-1:0] zhi;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, zlo, zhi, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, zlo, zhi, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) engine with start/busy/done handshake.
// Optional: define MULDIV_RADIX4_EN for radix-4 Booth multiply (WIDTH/2 iterations).
module muldiv_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter logic [4:0]  OP_MUL = 5'b01111,
    parameter logic [4:0]  OP_DIV = 5'b10000
) (
    input  logic          clk,
    input  logic          reset_n,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned HW = WIDTH + 2;
`ifdef MULDIV_RADIX4_EN
    localparam logic [CW-1:0] ITER_MUL = CW'(WIDTH / 2);
`else
    localparam logic [CW-1:0] ITER_MUL = CW'(WIDTH);
`endif
    localparam logic [CW-1:0] ITER_DIV = CW'(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] zlo_q, zlo_d, zhi_q, zhi_d;

    logic [HW-1:0]    m_ext, mul_sum, mul_hi;
    logic [WIDTH-1:0] mul_lo, b_mag;
    logic             mul_qm1;
    logic [WIDTH:0]   rem_shift;
    logic [HW-1:0]    div_diff;
    logic             accept_c;

    assign m_ext    = {{2{a_q[WIDTH-1]}}, a_q};
    assign b_mag    = b_q[WIDTH-1] ? -b_q : b_q;
    assign accept_c = bus.start && ((bus.op == OP_MUL) || (bus.op == OP_DIV));

    // Booth step: add/subtract multiplicand into the high half, then arithmetic shift
    always_comb begin
        mul_sum = hi_q;
`ifdef MULDIV_RADIX4_EN
        case ({lo_q[1:0], qm1_q})
            3'b001, 3'b010: mul_sum = hi_q + m_ext;
            3'b011:         mul_sum = hi_q + {m_ext[HW-2:0], 1'b0};
            3'b100:         mul_sum = hi_q - {m_ext[HW-2:0], 1'b0};
            3'b101, 3'b110: mul_sum = hi_q - m_ext;
            default:        mul_sum = hi_q;
        endcase
        mul_hi  = {{2{mul_sum[HW-1]}}, mul_sum[HW-1:2]};
        mul_lo  = {mul_sum[1:0], lo_q[WIDTH-1:2]};
        mul_qm1 = lo_q[1];
`else
        case ({lo_q[0], qm1_q})
            2'b01:   mul_sum = hi_q + m_ext;
            2'b10:   mul_sum = hi_q - m_ext;
            default: mul_sum = hi_q;
        endcase
        mul_hi  = {mul_sum[HW-1], mul_sum[HW-1:1]};
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
        mul_qm1 = lo_q[0];
`endif
    end

    // Restoring divide: remainder in hi_q, dividend shifting out of / quotient into lo_q
    assign rem_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign div_diff  = {1'b0, rem_shift} - {2'b00, b_mag};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        zlo_d    = zlo_q;
        zhi_d    = zhi_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d  = S_RUN;
                    a_d      = bus.a;
                    b_d      = bus.b;
                    is_div_d = (bus.op == OP_DIV);
                    cnt_d    = '0;
                    hi_d     = '0;
                    qm1_d    = 1'b0;
                    lo_d     = (bus.op == OP_DIV) ? (bus.a[WIDTH-1] ? -bus.a : bus.a) : bus.b;
                    busy_d   = 1'b1;
                    dbz_d    = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    if (!div_diff[HW-1]) begin
                        hi_d = div_diff;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = {1'b0, rem_shift};
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d  = mul_hi;
                    lo_d  = mul_lo;
                    qm1_d = mul_qm1;
                end
                if (cnt_q == (is_div_q ? ITER_DIV : ITER_MUL) - CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    zhi_d = hi_q[WIDTH-1:0];
                    zlo_d = lo_q;
                    dbz_d = 1'b0;
                end else if (b_q == '0) begin
                    zlo_d = '1;
                    zhi_d = a_q;
                    dbz_d = 1'b1;
                end else begin
                    zlo_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) ? -lo_q : lo_q;
                    zhi_d = a_q[WIDTH-1] ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
                    dbz_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            zlo_q    <= '0;
            zhi_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
            zlo_q    <= zlo_d;
            zhi_q    <= zhi_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.zlo         = zlo_q;
    assign bus.zhi         = zhi_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, handshake, reset abort.
module tb_muldiv_unit;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
`ifdef MULDIV_RADIX4_EN
    localparam int LAT_MUL = 17;
`else
    localparam int LAT_MUL = 33;
`endif
    localparam int LAT_DIV = 33;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] prev_lo, prev_hi;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse; optional second start at edge 'repulse'
    task automatic run_op(input string tag, input logic [4:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input logic exp_dbz, input int repulse);
        int lat;
        int seen;
        lat = (op_v == OP_MUL) ? LAT_MUL : LAT_DIV;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        check_eq({tag, "_busy_acc"}, 64'(bus.busy), 64'd1);
        check_eq({tag, "_dbz_acc"}, 64'(bus.div_by_zero), 64'd0);
        check_eq({tag, "_zlo_hold"}, 64'(bus.zlo), 64'(prev_lo));
        seen = 0;
        for (int n = 1; n <= 40 && seen == 0; n++) begin
            if (repulse != 0 && n == repulse) begin
                bus.start = 1'b1;
                bus.op    = OP_DIV;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) seen = n;
            else if (n == lat - 1) check_eq({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
        end
        check_eq({tag, "_latency"}, 64'(seen), 64'(lat));
        check_eq({tag, "_zlo"}, 64'(bus.zlo), 64'(exp_lo));
        check_eq({tag, "_zhi"}, 64'(bus.zhi), 64'(exp_hi));
        check_eq({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_zhi_idle"}, 64'(bus.zhi), 64'(exp_hi));
        prev_lo = exp_lo;
        prev_hi = exp_hi;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        checks    = 0;
        failures  = 0;
        prev_lo   = '0;
        prev_hi   = '0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_zlo", 64'(bus.zlo), 64'd0);
        check_eq("rst_zhi", 64'(bus.zhi), 64'd0);
        check_eq("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7xm3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("mul_minsq", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, 0);
        run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 0);
        run_op("div_m100dm7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("div_by0", OP_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 0);
        run_op("mul_repulse", OP_MUL, 32'hFFFF_FB2E, 32'd5678, 32'hFF95_1644, 32'hFFFF_FFFF, 1'b0, 10);

        // Unsupported opcode must leave the unit idle
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 5'b00011;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("badop_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        check_eq("badop_nodone", 64'(seen), 64'd0);
        check_eq("badop_zlo", 64'(bus.zlo), 64'(prev_lo));

        // Reset in flight abandons the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_busy", 64'(bus.busy), 64'd0);
        check_eq("rstmid_done", 64'(bus.done), 64'd0);
        check_eq("rstmid_zlo", 64'(bus.zlo), 64'd0);
        check_eq("rstmid_zhi", 64'(bus.zhi), 64'd0);
        check_eq("rstmid_dbz", 64'(bus.div_by_zero), 64'd0);
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1;
        end
        check_eq("rstmid_nodone", 64'(seen), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_lo = '0;
        prev_hi = '0;
        run_op("mul_after_rst", OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
